// File: rtl/mccpu_pkg.sv
// mccpu shared definitions: FSM states, opcodes,
// control encodings and ALU/EXT helpers.
package mccpu_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_PASSB
  } alu_op_t;

  typedef enum logic [1:0] {
    NPC_PC4, NPC_BR, NPC_J, NPC_JR
  } npc_op_t;

  typedef enum logic [1:0] {
    WD_ALU, WD_MEM, WD_PC4
  } wd_sel_t;

  typedef enum logic [1:0] {
    GPR_RD, GPR_RT, GPR_RA
  } gpr_sel_t;

  typedef enum logic [1:0] {
    EXT_ZERO, EXT_SIGN, EXT_LUI
  } ext_op_t;

  typedef enum logic [3:0] {
    K_NOP, K_RALU, K_IALU, K_LOAD, K_STORE,
    K_BEQ, K_BNE, K_J, K_JAL, K_JR
  } kind_t;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_HU = 3'd2;
  localparam logic [2:0] LD_B  = 3'd3;
  localparam logic [2:0] LD_BU = 3'd4;

  localparam logic [1:0] SV_W = 2'd0;
  localparam logic [1:0] SV_H = 2'd1;
  localparam logic [1:0] SV_B = 2'd2;

  function automatic logic [31:0] alu_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input alu_op_t     op
  );
    logic [31:0] c;
    case (op)
      ALU_ADD:   c = a + b;
      ALU_SUB:   c = a - b;
      ALU_AND:   c = a & b;
      ALU_OR:    c = a | b;
      ALU_XOR:   c = a ^ b;
      ALU_NOR:   c = ~(a | b);
      ALU_SLT:   c = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:  c = {31'd0, a < b};
      ALU_SLL:   c = b << a[4:0];
      ALU_SRL:   c = b >> a[4:0];
      ALU_SRA:   c = 32'($signed(b) >>> a[4:0]);
      ALU_PASSB: c = b;
      default:   c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] ext_f(
    input logic [15:0] imm,
    input ext_op_t     op
  );
    logic [31:0] r;
    case (op)
      EXT_ZERO: r = {16'd0, imm};
      EXT_LUI:  r = {imm, 16'd0};
      default:  r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mccpu_ctrl.sv
// mccpu control: instruction decode plus the
// FETCH/DECODE/EXEC/MEM/WB sequencer.
module mc_ctrl
  import mccpu_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic     imem_ready,
  input  logic     dmem_ready,
  input  logic     zero,
  output state_t   state,
  output logic     imem_req,
  output logic     dmem_req,
  output logic     mem_write,
  output logic     reg_write,
  output logic     alu_src,
  output logic     areg_sel,
  output ext_op_t  ext_op,
  output alu_op_t  alu_op,
  output npc_op_t  npc_op,
  output wd_sel_t  wd_sel,
  output gpr_sel_t gpr_sel,
  output logic [2:0] ld,
  output logic [1:0] sv,
  output logic     ir_we,
  output logic     ab_we,
  output logic     aluout_we,
  output logic     mdr_we,
  output logic     pc_we
);

  state_t nxt;
  kind_t  kind;

  // Decode the held IR into an instruction class
  always_comb begin
    kind     = K_NOP;
    alu_op   = ALU_ADD;
    alu_src  = 1'b0;
    areg_sel = 1'b0;
    ext_op   = EXT_SIGN;
    ld       = LD_W;
    sv       = SV_W;
    case (op)
      OP_RTYPE: begin
        kind = K_RALU;
        case (funct)
          F_SLL:  begin
            alu_op = ALU_SLL; areg_sel = 1'b1;
          end
          F_SRL:  begin
            alu_op = ALU_SRL; areg_sel = 1'b1;
          end
          F_SRA:  begin
            alu_op = ALU_SRA; areg_sel = 1'b1;
          end
          F_ADD, F_ADDU: alu_op = ALU_ADD;
          F_SUB, F_SUBU: alu_op = ALU_SUB;
          F_AND:  alu_op = ALU_AND;
          F_OR:   alu_op = ALU_OR;
          F_XOR:  alu_op = ALU_XOR;
          F_NOR:  alu_op = ALU_NOR;
          F_SLT:  alu_op = ALU_SLT;
          F_SLTU: alu_op = ALU_SLTU;
          F_JR:   kind = K_JR;
          default: kind = K_NOP;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        kind = K_IALU; alu_src = 1'b1;
      end
      OP_SLTI: begin
        kind = K_IALU; alu_src = 1'b1;
        alu_op = ALU_SLT;
      end
      OP_SLTIU: begin
        kind = K_IALU; alu_src = 1'b1;
        alu_op = ALU_SLTU;
      end
      OP_ANDI: begin
        kind = K_IALU; alu_src = 1'b1;
        alu_op = ALU_AND; ext_op = EXT_ZERO;
      end
      OP_ORI: begin
        kind = K_IALU; alu_src = 1'b1;
        alu_op = ALU_OR; ext_op = EXT_ZERO;
      end
      OP_XORI: begin
        kind = K_IALU; alu_src = 1'b1;
        alu_op = ALU_XOR; ext_op = EXT_ZERO;
      end
      OP_LUI: begin
        kind = K_IALU; alu_src = 1'b1;
        alu_op = ALU_PASSB; ext_op = EXT_LUI;
      end
      OP_LW:  begin
        kind = K_LOAD; alu_src = 1'b1; ld = LD_W;
      end
      OP_LH:  begin
        kind = K_LOAD; alu_src = 1'b1; ld = LD_H;
      end
      OP_LHU: begin
        kind = K_LOAD; alu_src = 1'b1; ld = LD_HU;
      end
      OP_LB:  begin
        kind = K_LOAD; alu_src = 1'b1; ld = LD_B;
      end
      OP_LBU: begin
        kind = K_LOAD; alu_src = 1'b1; ld = LD_BU;
      end
      OP_SW:  begin
        kind = K_STORE; alu_src = 1'b1; sv = SV_W;
      end
      OP_SH:  begin
        kind = K_STORE; alu_src = 1'b1; sv = SV_H;
      end
      OP_SB:  begin
        kind = K_STORE; alu_src = 1'b1; sv = SV_B;
      end
      OP_BEQ: begin
        kind = K_BEQ; alu_op = ALU_SUB;
      end
      OP_BNE: begin
        kind = K_BNE; alu_op = ALU_SUB;
      end
      OP_J:   kind = K_J;
      OP_JAL: kind = K_JAL;
      default: kind = K_NOP;
    endcase
  end

  // Write-back destination and data source
  always_comb begin
    wd_sel  = WD_ALU;
    gpr_sel = GPR_RD;
    unique case (1'b1)
      kind == K_JAL: begin
        wd_sel = WD_PC4; gpr_sel = GPR_RA;
      end
      kind == K_LOAD: begin
        wd_sel = WD_MEM; gpr_sel = GPR_RT;
      end
      kind == K_IALU: gpr_sel = GPR_RT;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  // Next state and per-state enables
  always_comb begin
    nxt       = state;
    reg_write = 1'b0;
    npc_op    = NPC_PC4;
    ir_we     = 1'b0;
    ab_we     = 1'b0;
    aluout_we = 1'b0;
    mdr_we    = 1'b0;
    pc_we     = 1'b0;
    unique case (state)
      S_FETCH: begin
        if (imem_ready) begin
          ir_we = 1'b1;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        ab_we = 1'b1;
        nxt   = S_EXEC;
      end
      S_EXEC: begin
        aluout_we = 1'b1;
        nxt       = S_FETCH;
        case (kind)
          K_RALU, K_IALU, K_JAL: nxt = S_WB;
          K_LOAD, K_STORE:       nxt = S_MEM;
          K_BEQ: begin
            pc_we  = 1'b1;
            npc_op = zero ? NPC_BR : NPC_PC4;
          end
          K_BNE: begin
            pc_we  = 1'b1;
            npc_op = zero ? NPC_PC4 : NPC_BR;
          end
          K_J: begin
            pc_we = 1'b1; npc_op = NPC_J;
          end
          K_JR: begin
            pc_we = 1'b1; npc_op = NPC_JR;
          end
          default: pc_we = 1'b1;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (kind == K_LOAD) begin
            mdr_we = 1'b1;
            nxt    = S_WB;
          end else begin
            pc_we = 1'b1;
            nxt   = S_FETCH;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        npc_op    = (kind == K_JAL) ? NPC_J : NPC_PC4;
        nxt       = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

  assign imem_req  = (state == S_FETCH) & ~rst;
  assign dmem_req  = (state == S_MEM) & ~rst;
  assign mem_write = dmem_req & (kind == K_STORE);

endmodule

// File: rtl/mccpu.sv
// mccpu top: multi-cycle MIPS datapath with
// handshaked memories and debug counters.
module mccpu
  import mccpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          CNT_W    = 32,
  parameter bit          DBG_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [31:0]      PC,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [31:0]      instr,
  output logic             dmem_req,
  output logic             MemWrite,
  output logic [31:0]      aluout,
  output logic [31:0]      writedata,
  input  logic [31:0]      readdata,
  input  logic             dmem_ready,
  output logic [2:0]       LD,
  output logic [1:0]       SV,
  input  logic [4:0]       reg_sel,
  output logic [31:0]      reg_data,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state_dbg
);

  state_t   state;
  logic     reg_write, alu_src, areg_sel, zero;
  ext_op_t  ext_op;
  alu_op_t  alu_op;
  npc_op_t  npc_op;
  wd_sel_t  wd_sel;
  gpr_sel_t gpr_sel;
  logic     ir_we, ab_we, aluout_we, mdr_we, pc_we;

  logic [31:0] ir, a_q, imm_q, mdr;
  logic [31:0] rf [32];
  logic [31:0] rd1, rd2, alu_a, alu_b, c;
  logic [31:0] pc4, npc, wd;
  logic [4:0]  a3;

  mc_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .op         (ir[31:26]),
    .funct      (ir[5:0]),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .zero       (zero),
    .state      (state),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .mem_write  (MemWrite),
    .reg_write  (reg_write),
    .alu_src    (alu_src),
    .areg_sel   (areg_sel),
    .ext_op     (ext_op),
    .alu_op     (alu_op),
    .npc_op     (npc_op),
    .wd_sel     (wd_sel),
    .gpr_sel    (gpr_sel),
    .ld         (LD),
    .sv         (SV),
    .ir_we      (ir_we),
    .ab_we      (ab_we),
    .aluout_we  (aluout_we),
    .mdr_we     (mdr_we),
    .pc_we      (pc_we)
  );

  assign state_dbg = state;

  assign rd1 = rf[ir[25:21]];
  assign rd2 = rf[ir[20:16]];

  // Shift amount feeds the ALU A side for sll/srl/sra
  assign alu_a = areg_sel ? {27'd0, ir[10:6]} : a_q;
  assign alu_b = alu_src ? imm_q : writedata;
  assign c     = alu_f(alu_a, alu_b, alu_op);
  assign zero  = (c == 32'd0);

  assign pc4 = PC + 32'd4;

  // Next PC: PC still holds this instruction's address
  always_comb begin
    npc = pc4;
    case (npc_op)
      NPC_BR: npc = pc4 + {imm_q[29:0], 2'b00};
      NPC_J:  npc = {PC[31:28], ir[25:0], 2'b00};
      NPC_JR: npc = a_q;
      default: npc = pc4;
    endcase
  end

  // Write-back destination and data muxes
  always_comb begin
    a3 = ir[15:11];
    wd = aluout;
    unique case (gpr_sel)
      GPR_RT:  a3 = ir[20:16];
      GPR_RA:  a3 = 5'd31;
      default: a3 = ir[15:11];
    endcase
    unique case (wd_sel)
      WD_MEM:  wd = mdr;
      WD_PC4:  wd = pc4;
      default: wd = aluout;
    endcase
  end

  // Register file; $0 never written so it reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (reg_write && a3 != 5'd0) begin
      rf[a3] <= wd;
    end
  end

  // Datapath registers and PC
  always_ff @(posedge clk) begin
    if (rst) begin
      PC        <= RESET_PC;
      ir        <= '0;
      a_q       <= '0;
      writedata <= '0;
      imm_q     <= '0;
      aluout    <= '0;
      mdr       <= '0;
    end else begin
      if (ir_we) ir <= instr;
      if (ab_we) begin
        a_q       <= rd1;
        writedata <= rd2;
        imm_q     <= ext_f(ir[15:0], ext_op);
      end
      if (aluout_we) aluout <= c;
      if (mdr_we)    mdr    <= readdata;
      if (pc_we)     PC     <= npc;
    end
  end

  // Cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_we) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  if (DBG_EN) begin : g_dbg
    assign reg_data = rf[reg_sel];
  end else begin : g_nodbg
    assign reg_data = '0;
  end

endmodule

// File: tb/tb_mccpu.sv
// Directed bench for mccpu: small program with
// memory wait states, branches, jumps and reset abort.
module tb_mccpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] instr;
  logic        dmem_req;
  logic        MemWrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        dmem_ready;
  logic [2:0]  LD;
  logic [1:0]  SV;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] imem [16];
  logic [31:0] dmem [16];
  int          dwait = 0;
  int          dcnt = 0;
  logic        dmem_force = 1'b0;

  mccpu dut (
    .clk        (clk),
    .rst        (rst),
    .PC         (PC),
    .imem_req   (imem_req),
    .imem_ready (imem_ready),
    .instr      (instr),
    .dmem_req   (dmem_req),
    .MemWrite   (MemWrite),
    .aluout     (aluout),
    .writedata  (writedata),
    .readdata   (readdata),
    .dmem_ready (dmem_ready),
    .LD         (LD),
    .SV         (SV),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  assign instr    = imem[PC[5:2]];
  assign readdata = dmem[aluout[5:2]];
  assign dmem_ready = dmem_force |
    (dmem_req && dcnt >= dwait);

  // Data memory wait-state counter and store port
  always @(posedge clk) begin
    if (dmem_req && !dmem_ready) dcnt <= dcnt + 1;
    else                         dcnt <= 0;
    if (dmem_req && MemWrite && dmem_ready)
      dmem[aluout[5:2]] <= writedata;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag,
                           input logic [4:0] r,
                           input logic [31:0] exp);
    reg_sel = r;
    #1;
    check(tag, reg_data, exp);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      imem[i] = 32'h0;
      dmem[i] = 32'hDEAD_BEEF;
    end
    imem[0]  = 32'h3401_0005; // ori  $1,$0,5
    imem[1]  = 32'h2022_FFFE; // addi $2,$1,-2
    imem[2]  = 32'hAC02_0000; // sw   $2,0($0)
    imem[3]  = 32'h8C03_0000; // lw   $3,0($0)
    imem[4]  = 32'h1021_0002; // beq  $1,$1,+2
    imem[7]  = 32'h1421_0002; // bne  $1,$1,+2
    imem[8]  = 32'h0C00_0C00; // jal  0x0C00
    imem[9]  = 32'hFC00_0000; // undefined
    imem[10] = 32'h2000_0007; // addi $0,$0,7
    imem[11] = 32'hAC02_0004; // sw   $2,4($0)

    rst        = 1'b1;
    imem_ready = 1'b1;
    reg_sel    = 5'd0;
    cyc(2);
    check("rst_pc", PC, 32'h3000);
    check("rst_imem_req", {31'd0, imem_req}, 0);
    check("rst_dmem_req", {31'd0, dmem_req}, 0);
    check("rst_state", {29'd0, state_dbg}, 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_instr", instr_cnt, 0);
    check("rst_aluout", aluout, 0);

    rst = 1'b0;
    #1;
    check("fetch_req", {31'd0, imem_req}, 1);

    // ori / addi with zero waits
    cyc(4);
    check_reg("ori_r1", 5'd1, 32'd5);
    check("ori_pc", PC, 32'h3004);
    check("ori_cycle", cycle_cnt, 4);
    cyc(4);
    check_reg("addi_r2", 5'd2, 32'd3);
    check("addi_pc", PC, 32'h3008);
    check("addi_cnt", instr_cnt, 2);
    check("addi_cycle", cycle_cnt, 8);
    imem[0] = 32'h03E0_0008; // jr $31

    // sw with two data wait states
    dwait = 2;
    cyc(3);
    check("sw_state", {29'd0, state_dbg}, 3);
    check("sw_req", {31'd0, dmem_req}, 1);
    check("sw_we", {31'd0, MemWrite}, 1);
    check("sw_addr", aluout, 0);
    check("sw_data", writedata, 3);
    check("sw_sv", {30'd0, SV}, 0);
    cyc(2);
    check("sw_hold_req", {31'd0, dmem_req}, 1);
    check("sw_hold_addr", aluout, 0);
    check("sw_hold_data", writedata, 3);
    check("sw_hold_pc", PC, 32'h3008);
    cyc(1);
    check("sw_pc", PC, 32'h300C);
    check("sw_mem", dmem[0], 32'd3);
    check("sw_cnt", instr_cnt, 3);

    // lw with two data wait states
    cyc(3);
    check("lw_req", {31'd0, dmem_req}, 1);
    check("lw_we", {31'd0, MemWrite}, 0);
    check("lw_ld", {29'd0, LD}, 0);
    cyc(3);
    check("lw_wb_state", {29'd0, state_dbg}, 4);
    cyc(1);
    check_reg("lw_r3", 5'd3, 32'd3);
    check("lw_pc", PC, 32'h3010);
    dwait = 0;

    // beq taken, bne not taken
    cyc(3);
    check("beq_pc", PC, 32'h301C);
    check("beq_cnt", instr_cnt, 5);
    check("beq_state", {29'd0, state_dbg}, 0);
    cyc(3);
    check("bne_pc", PC, 32'h3020);
    check("bne_cnt", instr_cnt, 6);

    // jal then jr; stray dmem_ready is ignored
    cyc(4);
    check("jal_pc", PC, 32'h3000);
    check_reg("jal_r31", 5'd31, 32'h3024);
    dmem_force = 1'b1;
    cyc(3);
    check("jr_pc", PC, 32'h3024);
    check("jr_cnt", instr_cnt, 8);
    dmem_force = 1'b0;

    // undefined opcode with one fetch wait
    imem_ready = 1'b0;
    cyc(1);
    check("fwait_state", {29'd0, state_dbg}, 0);
    check("fwait_req", {31'd0, imem_req}, 1);
    check("fwait_pc", PC, 32'h3024);
    imem_ready = 1'b1;
    cyc(3);
    check("undef_pc", PC, 32'h3028);
    check("undef_cnt", instr_cnt, 9);
    cyc(4);
    check("addi0_pc", PC, 32'h302C);
    check_reg("addi0_r0", 5'd0, 32'd0);
    check("addi0_cnt", instr_cnt, 10);
    check("total_cycle", cycle_cnt, 42);

    // reset during a stalled store
    dwait = 5;
    cyc(3);
    check("abort_req", {31'd0, dmem_req}, 1);
    check("abort_addr", aluout, 32'd4);
    cyc(1);
    rst = 1'b1;
    cyc(1);
    check("abort_dreq", {31'd0, dmem_req}, 0);
    check("abort_ireq", {31'd0, imem_req}, 0);
    check("abort_pc", PC, 32'h3000);
    check("abort_cycle", cycle_cnt, 0);
    check("abort_instr", instr_cnt, 0);
    check("abort_state", {29'd0, state_dbg}, 0);
    rst = 1'b0;
    dwait = 0;
    cyc(1);
    check("abort_mem", dmem[1], 32'hDEAD_BEEF);
    check_reg("abort_rf", 5'd2, 32'd0);
    check("post_cycle", cycle_cnt, 1);
    check("post_state", {29'd0, state_dbg}, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
